// File: rtl/alu_seq_n.sv
// Sequential add/sub, signed Booth multiply and unsigned non-restoring divide with start/done control.
// Macro ALU_DIV_EN compiles in the divider and its FIX state; without it op=11 reports err.
module alu_seq_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z,
  output logic               err
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                op_q, op_d;
  logic signed [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]          q_q, q_d;
  logic                      qm1_q, qm1_d;
  logic [WIDTH-1:0]          m_q, m_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]        z_q, z_d;
  logic                      err_q, err_d;
  logic                      accept;
  logic                      last;

  // Add/sub on sign-extended operands, result sign-extended to the full z width.
  function automatic logic [2*WIDTH-1:0] addsub(input logic sub, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH:0] ae, be, r;
    ae = $signed({a[WIDTH-1], a});
    be = $signed({b[WIDTH-1], b});
    r  = sub ? ae - be : ae + be;
    return {{(WIDTH-1){r[WIDTH]}}, r};
  endfunction

  // One Booth radix-2 iteration; A carries a guard bit so M = -2^(WIDTH-1) cannot overflow.
  function automatic logic [2*WIDTH+1:0] booth_step(input logic signed [WIDTH:0] a,
                                                    input logic [WIDTH-1:0] q, input logic qm1,
                                                    input logic [WIDTH-1:0] m);
    logic signed [WIDTH:0] ms, sum;
    logic [2*WIDTH+1:0]    cat;
    ms = $signed({m[WIDTH-1], m});
    case ({q[0], qm1})
      2'b01:   sum = a + ms;
      2'b10:   sum = a - ms;
      default: sum = a;
    endcase
    cat = {sum, q, qm1};
    return {cat[2*WIDTH+1], cat[2*WIDTH+1:1]};
  endfunction

`ifdef ALU_DIV_EN
  // One non-restoring iteration; the add/sub choice follows the sign of A before the shift.
  function automatic logic [2*WIDTH:0] div_step(input logic signed [WIDTH:0] a,
                                                input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] m);
    logic signed [WIDTH:0] ash, mz, res;
    mz  = $signed({1'b0, m});
    ash = $signed({a[WIDTH-1:0], q[WIDTH-1]});
    res = a[WIDTH] ? ash + mz : ash - mz;
    return {res, q[WIDTH-2:0], ~res[WIDTH]};
  endfunction
`endif

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last   = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_DONE;
        if (op_q == OP_MUL) state_d = S_RUN;
`ifdef ALU_DIV_EN
        if ((op_q == OP_DIV) && (m_q != '0)) state_d = S_RUN;
`endif
      end
      S_RUN: begin
        if (last) begin
`ifdef ALU_DIV_EN
          state_d = (op_q == OP_DIV) ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = accept ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD, S_RUN, S_FIX: busy = 1'b1;
      S_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: Q and M hold the captured operands until LOAD primes A and the counter.
  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    z_d   = z_q;
    err_d = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d  = op;
          q_d   = a_in;
          m_d   = b_in;
          err_d = 1'b0;
        end
      end
      S_LOAD: begin
        acc_d = '0;
        qm1_d = 1'b0;
        cnt_d = '0;
        case (op_q)
          OP_ADD: z_d = addsub(1'b0, q_q, m_q);
          OP_SUB: z_d = addsub(1'b1, q_q, m_q);
          OP_MUL: ;
          OP_DIV: begin
`ifdef ALU_DIV_EN
            if (m_q == '0) begin
              z_d   = {q_q, {WIDTH{1'b1}}};
              err_d = 1'b1;
            end
`else
            z_d   = '0;
            err_d = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      S_RUN: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef ALU_DIV_EN
        if (op_q == OP_DIV) begin
          {acc_d, q_d} = div_step(acc_q, q_q, m_q);
        end else begin
          {acc_d, q_d, qm1_d} = booth_step(acc_q, q_q, qm1_q, m_q);
          if (last) z_d = {acc_d[WIDTH-1:0], q_d};
        end
`else
        {acc_d, q_d, qm1_d} = booth_step(acc_q, q_q, qm1_q, m_q);
        if (last) z_d = {acc_d[WIDTH-1:0], q_d};
`endif
      end
      S_FIX: begin
`ifdef ALU_DIV_EN
        if (acc_q[WIDTH]) acc_d = acc_q + $signed({1'b0, m_q});
        z_d = {acc_d[WIDTH-1:0], q_q};
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      acc_q <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
      z_q   <= '0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
      err_q <= err_d;
    end
  end

  assign z   = z_q;
  assign err = err_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n: WIDTH=8 and WIDTH=16 instances against an arithmetic reference model.
module tb_alu_seq_n;

  logic        clk;
  logic        rst;
  logic        start8, start16;
  logic [1:0]  op_t;
  logic [31:0] a_t, b_t;
  logic        busy8, done8, err8;
  logic [15:0] z8;
  logic        busy16, done16, err16;
  logic [31:0] z16;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op_t), .a_in(a_t[7:0]), .b_in(b_t[7:0]),
    .busy(busy8), .done(done8), .z(z8), .err(err8)
  );

  alu_seq_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op_t), .a_in(a_t[15:0]), .b_in(b_t[15:0]),
    .busy(busy16), .done(done16), .z(z16), .err(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_w(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain integer arithmetic on the operands as the programmer sees them.
  function automatic logic [63:0] ref_z(input int w, input logic [1:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint      sa, sb, r;
    ua = 64'(a) & mask_w(w);
    ub = 64'(b) & mask_w(w);
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    case (o)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sa * sb;
      default: begin
`ifdef ALU_DIV_EN
        if (ub == 64'd0) r = longint'((ua << w) | mask_w(w));
        else             r = longint'(((ua % ub) << w) | (ua / ub));
`else
        r = 0;
`endif
      end
    endcase
    return 64'(r) & mask_w(2 * w);
  endfunction

  function automatic int ref_lat(input int w, input logic [1:0] o, input logic [31:0] b);
    if (o == 2'b10) return w + 2;
    if (o == 2'b11) begin
`ifdef ALU_DIV_EN
      if ((64'(b) & mask_w(w)) != 64'd0) return w + 3;
`endif
      return 2;
    end
    return 2;
  endfunction

  function automatic logic ref_err(input int w, input logic [1:0] o, input logic [31:0] b);
    if (o != 2'b11) return 1'b0;
`ifdef ALU_DIV_EN
    return (64'(b) & mask_w(w)) == 64'd0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic obs_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic [63:0] obs_z(input int w);
    return (w == 8) ? 64'(z8) : 64'(z16);
  endfunction

  function automatic logic obs_err(input int w);
    return (w == 8) ? err8 : err16;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else        start16 = v;
  endtask

  // Called at a negedge; returns at the negedge of the cycle where done is seen.
  task automatic run_op(input int w, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [63:0] exp_z;
    int          exp_lat;
    logic        exp_err;
    int          n;
    bit          seen;
    exp_z   = ref_z(w, o, a, b);
    exp_lat = ref_lat(w, o, b);
    exp_err = ref_err(w, o, b);
    op_t = o;
    a_t  = a;
    b_t  = b;
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    set_start(w, 1'b0);
    op_t = 2'($urandom);
    a_t  = $urandom;
    b_t  = $urandom;
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 64'(obs_busy(w)), 64'd1);
      if (poke && exp_lat > 5 && n == 3) begin
        op_t = 2'($urandom);
        a_t  = $urandom;
        b_t  = $urandom;
        set_start(w, 1'b1);
      end
      if (poke && exp_lat > 5 && n == 4) set_start(w, 1'b0);
      if (obs_done(w)) seen = 1;
    end
    check("done_latency", 64'(n), 64'(exp_lat));
    check("z", obs_z(w), exp_z);
    check("err", 64'(obs_err(w)), 64'(exp_err));
    check("busy_at_done", 64'(obs_busy(w)), 64'd0);
  endtask

  task automatic gap(input int w, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (i == 0) check("done_single_pulse", 64'(obs_done(w)), 64'd0);
    end
  endtask

  initial begin
    int  w, gp, prev_w;
    logic [1:0] o;
    logic [31:0] a, b;
    bit seen;
    rst = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    op_t = 2'b00;
    a_t = '0;
    b_t = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z8", 64'(z8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_err8", 64'(err8), 64'd0);
    check("rst_z16", 64'(z16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 2'b00, 32'h64, 32'h64, 0);
    gap(8, 1);
    run_op(8, 2'b01, 32'h05, 32'h07, 0);
    gap(8, 1);
    run_op(8, 2'b00, 32'h80, 32'h80, 0);
    gap(8, 1);
    run_op(8, 2'b10, 32'hFD, 32'h05, 0);
    run_op(8, 2'b10, 32'h80, 32'h80, 0);
    gap(8, 2);
    run_op(8, 2'b11, 32'd200, 32'd7, 1);
    gap(8, 1);
    run_op(8, 2'b11, 32'd9, 32'd0, 0);
    gap(8, 1);
    run_op(8, 2'b10, 32'h7F, 32'h81, 1);
    gap(8, 1);
    run_op(16, 2'b10, 32'h8000, 32'h7FFF, 0);
    gap(16, 1);
    run_op(16, 2'b11, 32'hFFFF, 32'h0003, 0);
    gap(16, 1);

    // Reset in the middle of a multiply: result discarded, no done afterwards.
    run_op(8, 2'b10, 32'h12, 32'h34, 0);
    gap(8, 1);
    op_t = 2'b10;
    a_t = 32'h55;
    b_t = 32'h66;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_z", 64'(z8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    check("midrst_no_done", 64'(seen), 64'd0);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1;
    start8 = 1'b1;
    op_t = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    check("rst_beats_start", 64'(busy8), 64'd0);

    prev_w = 8;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 2) == 0) ? 16 : 8;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      gp = $urandom_range(0, 2);
      if (gp > 0) gap(prev_w, gp);
      run_op(w, o, a, b, bit'($urandom_range(0, 1)));
      prev_w = w;
    end
    gap(prev_w, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
# alu_seq_n

Parametrised sequential arithmetic unit that computes add, sub, signed multiply and unsigned divide on WIDTH-bit operands. It integrates its own control FSM, iteration counter and start/done handshake, so it needs no external control-signal sequencing. It is the self-contained successor to the fixed 8-bit datapath and is the arithmetic engine the top-level ALU instantiates.

## Interface
- WIDTH, default 8: operand width; legal range 4..32.
- CNT_W, default $clog2(WIDTH): iteration counter width; derived, never overridden.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  00 add, 01 sub, 10 mul (signed, Booth radix-2), 11 div (unsigned, non-restoring).
- a_in  in  WIDTH  operand A / dividend; captured when start is accepted.
- b_in  in  WIDTH  operand B / divisor; captured when start is accepted.
- busy  out  1  high in LOAD, RUN and FIX.
- done  out  1  one-cycle pulse; z and err are valid from this cycle on.
- z  out  2*WIDTH  result.
- err  out  1  divide-by-zero or unsupported op; valid with done.

## Operation
- FSM states: IDLE, LOAD, RUN, FIX, DONE.
- IDLE, start=1: capture op, a_in and b_in; clear err; go to LOAD.
- LOAD, add/sub: compute the (WIDTH+1)-bit signed result; sign-extend it into z; go to DONE.
- LOAD, mul: A=0, Q=a, Q[-1]=0, M=b, cnt=0; go to RUN.
- LOAD, div with b≠0: A=0, Q=a, M=b, cnt=0; go to RUN.
- LOAD, div with b=0: z={a, all-ones}, err=1; go to DONE.
- RUN, mul, each cycle:
  - Q0,Q-1 = 01 gives A+=M; 10 gives A-=M.
  - Then arithmetic right shift of {A,Q,Q-1}; cnt++.
  - After WIDTH iterations, go to DONE with z={A,Q}.
- RUN, div, each cycle: shift {A,Q} left; if A ≥ 0 then A-=M, else A+=M; Q0 = ~A[msb]; cnt++. After WIDTH iterations, go to FIX.
- A is WIDTH+1 bits wide for div.
- FIX: if A < 0 then A+=M. Then z={A[WIDTH-1:0], Q}, i.e. {remainder, quotient}. Go to DONE.
- DONE: done=1 for one cycle. With start=1, behave as IDLE with start (back-to-back accept); otherwise go to IDLE.
- z holds its value until the next LOAD writes it.
- start while busy: ignored; not queued.
- a_in, b_in and op changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, z=0, done=0, busy=0, err=0, cnt=0, internal regs 0.
- Start accepted at edge k; busy is high from k+1.
- done latency after edge k:
  - add/sub: high in cycle k+2.
  - div by zero: high in cycle k+2.
  - mul: high in cycle k+WIDTH+2.
  - div: high in cycle k+WIDTH+3.
- busy falls in the same cycle done rises.
- rst mid-operation: next edge returns to reset values; the in-flight result is discarded and no done is emitted.
- rst and start in the same cycle: rst wins.
- Counter wraps at WIDTH-1 → RUN exit; no other wrap is reachable.

## Configuration
- ALU_DIV_EN defined: divide datapath and FIX state are compiled in; op=11 behaves as above.
- ALU_DIV_EN undefined: divider logic is removed. op=11 goes LOAD→DONE with z=0 and err=1, and done is high in cycle k+2.
- add, sub and mul are unaffected either way.

## Test plan
- WIDTH=8, add a=0x64, b=0x64 → done in cycle k+2, z=0x00C8, err=0.
- WIDTH=8, sub a=5, b=7 → z=0xFFFE, done in cycle k+2.
- WIDTH=8, mul a=0xFD (-3), b=5 → done in cycle k+10, z=0xFFF1. Back-to-back start in DONE, mul 0x80×0x80 → z=0x4000.
- WIDTH=8, div a=200, b=7 → done in cycle k+11, z=0x041C. Div a=9, b=0 → z=0x09FF, err=1 at k+2. With ALU_DIV_EN undefined → z=0, err=1.
- Start pulsed during RUN with different operands → ignored; original result delivered. rst asserted mid-mul → busy=0, z=0 next cycle; no done pulse.
- WIDTH=16, mul 0x8000×0x7FFF → z=0xC0008000, done in cycle k+18. Div 0xFFFF/0x0003 → z=0x00005555.
